// File: rtl/uart_rx_fifo_if.sv
// Bundles the receiver-side capture inputs and the host-side read/status
// signals of the UART receive FIFO. The host (or a test bench) uses the
// master view; the FIFO itself uses the slave view.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  // Receiver side
  logic [7:0]          rx_data;
  logic                rx_int;
  // Host control
  logic                flush;
  logic                rd_en;
  logic                ovf_clr;
  // Host read data and status
  logic [7:0]          rd_data;
  logic                rd_valid;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;

  modport master (
    output rx_data, rx_int, flush, rd_en, ovf_clr,
    input  rd_data, rd_valid, empty, full, count, overflow
  );

  modport slave (
    input  rx_data, rx_int, flush, rd_en, ovf_clr,
    output rd_data, rd_valid, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Captures one byte per UART frame (rx_int falling edge) into a circular FIFO drained by rd_en.
// Latency: byte visible 2 edges after rx_int first samples low; read data 1 cycle after rd_en.
// Backpressure: none toward the receiver; a byte arriving while full is dropped and sets sticky overflow.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_fifo_if.slave  bus
);

  localparam int unsigned         DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(1) << DEPTH_LOG2;

  // Edge-detect pipeline on rx_int
  logic s0_q, s0_d;
  logic s1_q, s1_d;

  // FIFO bookkeeping
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q,  count_d;

  // Registered host outputs
  logic [7:0] rd_data_q,  rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       overflow_q, overflow_d;

  // Storage; contents are meaningless until written, so no reset
  logic [7:0] mem_q [DEPTH];

  // Per-cycle events
  logic wr_stb;
  logic empty;
  logic full;
  logic rd_acc;
  logic wr_acc;
  logic drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // Decode write/read/drop events and compute next state; flush overrides both ports
  always_comb begin
    wr_stb = s1_q & ~s0_q;
    rd_acc = bus.rd_en & ~empty & ~bus.flush;
    // A read in the same cycle frees a slot, so a full FIFO still accepts the byte
    wr_acc = wr_stb & ~bus.flush & (~full | rd_acc);
    drop   = wr_stb & ~bus.flush & full & ~rd_acc;

    s0_d       = bus.rx_int;
    s1_d       = s0_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_data_d = mem_q[rd_ptr_q];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // A drop in the same cycle as a clear must remain visible to the host
    if (drop)             overflow_d = 1'b1;
    else if (bus.ovf_clr) overflow_d = 1'b0;
    else                  overflow_d = overflow_q;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte capture into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: fixed vector table, directed corner
// sequences and randomized traffic, all against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;

  uart_rx_fifo_if #(.DEPTH_LOG2(DL)) bus();

  uart_rx_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  // Reference model: a byte queue plus frame-level timing. A high-to-low
  // change of the sampled rx_int at edge n delivers the byte present at edge n+1.
  logic [7:0] mq [$];
  logic       m_ovf;
  logic [7:0] m_rd_data;
  logic       m_rd_valid;
  logic       m_prev;
  int         pend_edge;
  int         edge_n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%s] got=%0h want=%0h", phase, nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf      = 1'b0;
    m_rd_data  = 8'h00;
    m_rd_valid = 1'b0;
    m_prev     = 1'b0;
    pend_edge  = -1;
  endtask

  task automatic compare_model();
    chk("count",    32'(bus.count),    32'(mq.size()));
    chk("empty",    32'(bus.empty),    32'(mq.size() == 0));
    chk("full",     32'(bus.full),     32'(mq.size() == DEPTH));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
    chk("rd_data",  32'(bus.rd_data),  32'(m_rd_data));
  endtask

  // Drive one cycle of inputs, advance the model one edge, then compare
  task automatic step(input logic ri, input logic [7:0] dat, input logic re,
                      input logic fl, input logic oc);
    logic do_wr;
    logic do_rd;
    logic drop;
    bus.rx_int  = ri;
    bus.rx_data = dat;
    bus.rd_en   = re;
    bus.flush   = fl;
    bus.ovf_clr = oc;
    do_wr = (pend_edge == edge_n);
    if (m_prev && !ri) pend_edge = edge_n + 1;
    m_prev = ri;
    do_rd  = 1'b0;
    drop   = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      do_rd = re && (mq.size() > 0);
      if (do_rd) m_rd_data = mq.pop_front();
      if (do_wr) begin
        if (mq.size() < DEPTH) mq.push_back(dat);
        else drop = 1'b1;
      end
    end
    if (drop)    m_ovf = 1'b1;
    else if (oc) m_ovf = 1'b0;
    m_rd_valid = do_rd;
    @(posedge clk);
    #1;
    edge_n++;
    compare_model();
  endtask

  // One UART frame: busy, then low for the falling-edge sample and the capture edge
  task automatic frame(input logic [7:0] d, input logic re_on_wr, input logic fl_on_wr);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
    step(1'b0, d, 1'b0, 1'b0, 1'b0);
    step(1'b0, d, re_on_wr, fl_on_wr, 1'b0);
  endtask

  task automatic idle(input logic re);
    step(1'b0, 8'h00, re, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_empty",    32'(bus.empty),    32'd1);
    chk("rst_full",     32'(bus.full),     32'd0);
    chk("rst_count",    32'(bus.count),    32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_rd_data",  32'(bus.rd_data),  32'h00);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
  endtask

  typedef struct {
    logic       ri;
    logic [7:0] dat;
    logic       re;
    int         e_count;
    logic       e_empty;
    logic       e_valid;
    logic [7:0] e_data;
  } vec_t;

  vec_t vt [13];
  int   max_cnt;

  initial begin
    bus.rx_int  = 1'b0;
    bus.rx_data = 8'h00;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.ovf_clr = 1'b0;
    edge_n      = 0;
    model_reset();
    rst_n = 1'b0;
    #1;
    phase = "reset";
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Three frames 41/42/43, then three back-to-back reads and one read while empty
    vt[0]  = '{1'b1, 8'h41, 1'b0, 0, 1'b1, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 8'h41, 1'b0, 0, 1'b1, 1'b0, 8'h00};
    vt[2]  = '{1'b0, 8'h41, 1'b0, 1, 1'b0, 1'b0, 8'h00};
    vt[3]  = '{1'b1, 8'h42, 1'b0, 1, 1'b0, 1'b0, 8'h00};
    vt[4]  = '{1'b0, 8'h42, 1'b0, 1, 1'b0, 1'b0, 8'h00};
    vt[5]  = '{1'b0, 8'h42, 1'b0, 2, 1'b0, 1'b0, 8'h00};
    vt[6]  = '{1'b1, 8'h43, 1'b0, 2, 1'b0, 1'b0, 8'h00};
    vt[7]  = '{1'b0, 8'h43, 1'b0, 2, 1'b0, 1'b0, 8'h00};
    vt[8]  = '{1'b0, 8'h43, 1'b0, 3, 1'b0, 1'b0, 8'h00};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b1, 8'h41};
    vt[10] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b1, 8'h42};
    vt[11] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, 8'h43};
    vt[12] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h43};
    phase = "table";
    for (int i = 0; i < 13; i++) begin
      step(vt[i].ri, vt[i].dat, vt[i].re, 1'b0, 1'b0);
      chk($sformatf("vec%0d_count", i), 32'(bus.count),    32'(vt[i].e_count));
      chk($sformatf("vec%0d_empty", i), 32'(bus.empty),    32'(vt[i].e_empty));
      chk($sformatf("vec%0d_valid", i), 32'(bus.rd_valid), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d_data", i),  32'(bus.rd_data),  32'(vt[i].e_data));
    end

    // Fill to 16, drop a 17th, drain in order, then clear overflow
    phase = "fill";
    for (int i = 0; i < 16; i++) frame(8'(i), 1'b0, 1'b0);
    chk("fill_full",  32'(bus.full),  32'd1);
    chk("fill_count", 32'(bus.count), 32'd16);
    frame(8'hAA, 1'b0, 1'b0);
    chk("drop_overflow", 32'(bus.overflow), 32'd1);
    chk("drop_count",    32'(bus.count),    32'd16);
    phase = "drain";
    for (int i = 0; i < 16; i++) begin
      idle(1'b1);
      chk($sformatf("drain%0d", i), 32'(bus.rd_data), 32'(i));
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(bus.overflow), 32'd0);

    // Full with a write and a read in the same cycle
    phase = "full_rw";
    for (int i = 0; i < 16; i++) frame(8'h80 + 8'(i), 1'b0, 1'b0);
    frame(8'h55, 1'b1, 1'b0);
    chk("rw_data",  32'(bus.rd_data),  32'h80);
    chk("rw_count", 32'(bus.count),    32'd16);
    chk("rw_ovf",   32'(bus.overflow), 32'd0);
    for (int i = 0; i < 16; i++) idle(1'b1);
    chk("rw_last", 32'(bus.rd_data), 32'h55);

    // Wrap-around: 40 write/read pairs
    phase = "wrap";
    max_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      frame(8'(i + 8'h10), 1'b0, 1'b0);
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      idle(1'b1);
      chk($sformatf("wrap%0d", i), 32'(bus.rd_data), 32'(i + 8'h10));
    end
    chk("wrap_max_count", 32'(max_cnt), 32'd1);

    // Flush with 5 entries and a coincident frame write
    phase = "flush";
    for (int i = 0; i < 5; i++) frame(8'hC0 + 8'(i), 1'b0, 1'b0);
    frame(8'hEE, 1'b0, 1'b1);
    chk("flush_count", 32'(bus.count),    32'd0);
    chk("flush_empty", 32'(bus.empty),    32'd1);
    chk("flush_ovf",   32'(bus.overflow), 32'd0);
    idle(1'b1);
    chk("flush_no_valid", 32'(bus.rd_valid), 32'd0);

    // Reset mid-frame with 4 entries and overflow set
    phase = "reset_mid";
    for (int i = 0; i < 17; i++) frame(8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) idle(1'b1);
    chk("pre_rst_count", 32'(bus.count),    32'd4);
    chk("pre_rst_ovf",   32'(bus.overflow), 32'd1);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
    #4;
    rst_n = 1'b0;
    bus.rx_int = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b0);
    chk("post_rst_no_write", 32'(bus.count), 32'd0);
    frame(8'h99, 1'b0, 1'b0);
    chk("post_rst_frame", 32'(bus.count), 32'd1);
    idle(1'b1);
    chk("post_rst_data", 32'(bus.rd_data), 32'h99);

    // Randomized traffic: write-heavy phase then read-heavy phase
    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      logic ri, re, fl, oc;
      ri = 1'($urandom_range(0, 1));
      re = (i < 1500) ? ($urandom_range(0, 99) < 15) : ($urandom_range(0, 99) < 70);
      fl = ($urandom_range(0, 199) == 0);
      oc = ($urandom_range(0, 39) == 0);
      step(ri, 8'($urandom), re, fl, oc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
